rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter
// Description : Two-port round-robin arbiter in front of a synchronous ROM.
//               Port 0 is instruction fetch, port 1 is data. One access is in
//               flight at a time: grant in IDLE, address issued in ISSUE,
//               response passed through in RESP.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter #(
   parameter  int AW     = 4,
   parameter  int EXTRA  = 4,
   localparam int DW_OUT = (2 ** EXTRA) * 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [AW:0]       addr0,
   input  logic [AW:0]       addr1,
   input  logic [EXTRA-1:0]  extra0,
   input  logic [EXTRA-1:0]  extra1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              valid0,
   output logic              valid1,
   output logic [DW_OUT-1:0] rdata,
   output logic              rerror,
   output logic [AW:0]       mem_addr,
   output logic [EXTRA-1:0]  mem_extra,
   input  logic [DW_OUT-1:0] mem_data,
   input  logic              mem_error
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;   // 0 = port 0 owns the access, 1 = port 1
   logic             last_q,  last_d;    // port served most recently
   logic [AW:0]      mem_addr_q,  mem_addr_d;
   logic [EXTRA-1:0] mem_extra_q, mem_extra_d;

   logic             w_win0;
   logic             w_win1;

   // Arbitration: a lone requester always wins; on a tie the port that was
   // not served last wins (last_q == 1 means port 0 has priority).
   always_comb begin
      w_win0 = req0 & (~req1 | last_q);
      w_win1 = req1 & ~w_win0;
   end

   // Next-state and output decode; outputs are forced quiet while reset is high
   // so an access interrupted by reset never produces a grant or a valid pulse.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      mem_addr_d  = mem_addr_q;
      mem_extra_d = mem_extra_q;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      valid0      = 1'b0;
      valid1      = 1'b0;
      rerror      = 1'b0;
      rdata       = mem_data;

      case (state_q)
         ST_IDLE: begin
            if (w_win0 | w_win1) begin
               gnt0        = w_win0;
               gnt1        = w_win1;
               owner_d     = w_win1;
               mem_addr_d  = w_win1 ? addr1  : addr0;
               mem_extra_d = w_win1 ? extra1 : extra0;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // ROM samples mem_addr/mem_extra at the end of this cycle.
            state_d = ST_RESP;
         end
         ST_RESP: begin
            valid0  = ~owner_q;
            valid1  = owner_q;
            rerror  = mem_error;
            last_d  = owner_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (reset) begin
         gnt0   = 1'b0;
         gnt1   = 1'b0;
         valid0 = 1'b0;
         valid1 = 1'b0;
         rerror = 1'b0;
      end
   end

   // State registers with synchronous reset taking priority over any transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         mem_addr_q  <= '0;
         mem_extra_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         mem_addr_q  <= mem_addr_d;
         mem_extra_q <= mem_extra_d;
      end
   end

   // The ROM address/extra come straight from the registers.
   assign mem_addr  = mem_addr_q;
   assign mem_extra = mem_extra_q;

endmodule
`default_nettype wire
